// File: rtl/regfile_mp_clr_if.sv
// rtl/regfile_mp_clr_if.sv - write/read/status bundle for regfile_mp_clr
interface regfile_mp_clr_if #(
  parameter int W   = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic              CLR;
  logic              LE;
  logic [AW-1:0]     RW;
  logic [W-1:0]      PW;
  logic [NRD*AW-1:0] RA;
  logic [NRD*W-1:0]  PA;
  logic              READY;
  logic              WR_DROP;

  modport master (output CLR, LE, RW, PW, RA, input PA, READY, WR_DROP);
  modport slave  (input CLR, LE, RW, PW, RA, output PA, READY, WR_DROP);
endinterface

// File: rtl/regfile_mp_clr.sv
// rtl/regfile_mp_clr.sv - multi-read-port register file with sequential clear engine
module regfile_mp_clr #(
  parameter int W        = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic             CLK,
  input logic             RST_N,
  regfile_mp_clr_if.slave bus
);
  typedef enum logic {ST_CLEARING, ST_READY} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

  state_t                state, state_nxt;
  logic [AW-1:0]         clr_idx, clr_idx_nxt;
  logic                  clr_we;
  logic                  wr_acc;
  logic                  drop_nxt;
  logic                  wr_drop;
  logic                  ready;
  logic [W-1:0]          mem [DEPTH];
  logic [NRD-1:0][W-1:0] pa_w;
  logic [AW-1:0]         ra;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  assign ready = (state == ST_READY);

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_we      = 1'b0;
    case (state)
      ST_CLEARING: begin
        clr_we = 1'b1;
        if (bus.CLR)                     clr_idx_nxt = '0;
        else if (clr_idx == LAST_IDX)    state_nxt   = ST_READY;
        else                             clr_idx_nxt = clr_idx + 1'b1;
      end
      default: begin
        if (bus.CLR) begin
          state_nxt   = ST_CLEARING;
          clr_idx_nxt = '0;
        end
      end
    endcase
  end

  // A zero-register write is neither accepted nor flagged as dropped.
  assign wr_acc   = ready && !bus.CLR && bus.LE && in_range(bus.RW) &&
                    !(ZERO_REG != 0 && bus.RW == '0);
  assign drop_nxt = bus.LE && (!ready || bus.CLR || !in_range(bus.RW));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= ST_CLEARING;
      clr_idx <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      wr_drop <= drop_nxt;
    end
  end

  // Storage has no reset of its own; the clear engine owns initialisation.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (clr_we)      mem[clr_idx] <= '0;
      else if (wr_acc) mem[bus.RW]  <= bus.PW;
    end
  end

  always_comb begin
    pa_w = '0;
    ra   = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = bus.RA[i*AW +: AW];
      if (!ready || !in_range(ra) || (ZERO_REG != 0 && ra == '0))
        pa_w[i] = '0;
      else if (BYPASS != 0 && wr_acc && bus.RW == ra)
        pa_w[i] = bus.PW;
      else
        pa_w[i] = mem[ra];
    end
  end

  assign bus.PA      = pa_w;
  assign bus.READY   = ready;
  assign bus.WR_DROP = wr_drop;
endmodule
